// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sa_state_e;

    localparam int SA_W = 8;

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder, reused every cycle by the serial sequencer.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: one full-adder cell stepped over W cycles, LSB first.
// Optional subtract mode (sub port) is enabled by defining SERIAL_ADD_SUB_EN.
//
// state   | meaning
// IDLE    | waiting for start, last result held
// RUN     | one operand bit pair consumed per enabled edge
// DONE    | result valid, done pulse; start here re-accepts immediately
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int W = SA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         start,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         carry_out
);

    localparam int CW = $clog2(W);

    sa_state_e       state_q, state_d;
    logic [W-1:0]    a_sh_q, a_sh_d;
    logic [W-1:0]    b_sh_q, b_sh_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [CW-1:0]   count_q, count_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            fa_s, fa_c;

    serial_fa_cell u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        count_d = count_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sh_d  = op_a;
                    count_d = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = ST_RUN;
`ifdef SERIAL_ADD_SUB_EN
                    // Two's-complement subtract: a + ~b + 1
                    b_sh_d  = sub ? ~op_b : op_b;
                    carry_d = sub;
`else
                    b_sh_d  = op_b;
                    carry_d = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                sum_d   = {fa_s, sum_q[W-1:1]};
                carry_d = fa_c;
                count_d = count_q + CW'(1);
                if (count_q == CW'(W - 1)) begin
                    state_d = ST_DONE;
                    cout_d  = fa_c;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq with a result scoreboard; subtract cases need SERIAL_ADD_SUB_EN.
module tb_serial_add_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;

    int checks = 0;
    int errors = 0;

    logic [W:0] sb_q[$];

    always #5 clk = ~clk;

    serial_add_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
        logic [W:0] r;
        if (s) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else   r = {1'b0, a} + {1'b0, b};
        return r;
    endfunction

    // Steps enabled/stalled edges after an accept until done is seen or the budget expires.
    task automatic wait_done(input int stall_at, input int stall_len,
                             output int lat, output int busy_n, output bit got);
        lat = 0;
        busy_n = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (i == stall_at) ena = 1'b0;
            if (i == stall_at + stall_len) ena = 1'b1;
            if (busy === 1'b1) busy_n++;
            tick();
            lat++;
            if (done === 1'b1) got = 1'b1;
        end
        ena = 1'b1;
    endtask

    task automatic check_result(input string tag, input int lat_exp, input int busy_exp,
                                input int lat, input int busy_n, input bit got);
        logic [W:0] e;
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(lat_exp));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(busy_exp));
        check({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
            check({tag, "_carry_out"}, 32'(carry_out), 32'(e[W]));
        end
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input int stall_at, input int stall_len);
        int lat, busy_n;
        bit got;
        logic [W-1:0] exp_sum;
        logic         exp_c;
        op_a = a;
        op_b = b;
        sub = s;
        start = 1'b1;
        sb_q.push_back(model(a, b, s));
        tick();
        start = 1'b0;
        op_a = ~a;
        op_b = ~b;
        check({tag, "_accept_clears_sum"}, 32'(sum), 32'd0);
        wait_done(stall_at, stall_len, lat, busy_n, got);
        exp_sum = sum;
        exp_c = carry_out;
        check_result(tag, W + stall_len, W + stall_len, lat, busy_n, got);
        tick();
        check({tag, "_done_single_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle_not_busy"}, 32'(busy), 32'd0);
        check({tag, "_sum_held"}, 32'({carry_out, sum}), 32'({exp_c, exp_sum}));
    endtask

    initial begin
        int lat, busy_n;
        bit got, seen_done;

        rst_n = 1'b0;
        ena = 1'b0;
        start = 1'b1;
        op_a = 8'd9;
        op_b = 8'd9;
        sub = 1'b0;
        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_carry", 32'(carry_out), 32'd0);
        start = 1'b0;
        ena = 1'b1;
        rst_n = 1'b1;
        tick();

        do_op("add_100_55", 8'd100, 8'd55, 1'b0, -1, 0);
        do_op("add_200_100", 8'd200, 8'd100, 1'b0, -1, 0);
        do_op("add_255_1", 8'd255, 8'd1, 1'b0, -1, 0);
        do_op("add_255_255", 8'd255, 8'd255, 1'b0, -1, 0);
        do_op("add_0_0", 8'd0, 8'd0, 1'b0, -1, 0);

        // start held through RUN with changing operands, then back-to-back re-accept from DONE
        op_a = 8'd10;
        op_b = 8'd20;
        start = 1'b1;
        sb_q.push_back(model(8'd10, 8'd20, 1'b0));
        tick();
        op_a = 8'd3;
        op_b = 8'd4;
        wait_done(-1, 0, lat, busy_n, got);
        check_result("held_start_first", W, W, lat, busy_n, got);
        sb_q.push_back(model(8'd3, 8'd4, 1'b0));
        tick();
        start = 1'b0;
        check("b2b_done_single_pulse", 32'(done), 32'd0);
        check("b2b_busy_reaccept", 32'(busy), 32'd1);
        wait_done(-1, 0, lat, busy_n, got);
        check_result("held_start_second", W, W, lat, busy_n, got);
        tick();
        check("b2b_end_done_low", 32'(done), 32'd0);

        // reset asserted at RUN edge 4 aborts without a done pulse
        op_a = 8'd100;
        op_b = 8'd55;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check("midrun_reset_busy", 32'(busy), 32'd0);
        check("midrun_reset_done", 32'(done), 32'd0);
        check("midrun_reset_sum", 32'(sum), 32'd0);
        check("midrun_reset_carry", 32'(carry_out), 32'd0);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
        end
        check("midrun_reset_no_done", 32'(seen_done), 32'd0);

        do_op("ena_stall", 8'd123, 8'd77, 1'b0, 3, 3);
        do_op("ena_stall_early", 8'd250, 8'd9, 1'b0, 0, 3);

`ifdef SERIAL_ADD_SUB_EN
        do_op("sub_5_7", 8'd5, 8'd7, 1'b1, -1, 0);
        do_op("sub_7_5", 8'd7, 8'd5, 1'b1, -1, 0);
        do_op("sub_9_9", 8'd9, 8'd9, 1'b1, -1, 0);
`endif

        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
